// File: rtl/matrix_stream_loader.sv
// Stream-to-parallel loader for the 4x4 determinant stage.
// Words arrive row-major on a valid/ready stream; every 16 words are assembled
// into one of two ping-pong register banks, and a completed bank is presented
// in parallel with its own valid/ready handshake. Filling one bank overlaps
// consumption of the other, so a matrix can leave every 16 cycles.
module matrix_stream_loader #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [16*DATA_W-1:0] mat_data,
   output logic                 mat_valid,
   input  logic                 mat_ready,
   output logic [3:0]           elem_cnt,
   output logic                 frame_err
);

   // Element k of a bank sits at bits [k*DATA_W +: DATA_W], matching mat_data.
   typedef logic [15:0][DATA_W-1:0] bank_t;

   bank_t      bank0_q, bank0_d;
   bank_t      bank1_q, bank1_d;
   logic [1:0] full_q, full_d;
   logic       wp_q, wp_d;
   logic       rp_q, rp_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ferr_q, ferr_d;

   logic       accept;
   logic       release_mat;
   logic       cnt_end;

   // Handshakes are gated by rst so nothing is accepted or released during reset.
   assign in_ready    = !full_q[wp_q] && !rst;
   assign mat_valid   = full_q[rp_q] && !rst;
   assign mat_data    = rp_q ? bank1_q : bank0_q;
   assign elem_cnt    = cnt_q;
   assign frame_err   = ferr_q;

   assign accept      = in_valid && in_ready;
   assign release_mat = mat_valid && mat_ready;
   assign cnt_end     = (cnt_q == 4'd15);

   // Next-state: element write, framing check/commit, and bank release.
   always_comb begin
      bank0_d = bank0_q;
      bank1_d = bank1_q;
      full_d  = full_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      cnt_d   = cnt_q;
      ferr_d  = 1'b0;

      if (accept) begin
         if (wp_q) begin
            bank1_d[cnt_q] = in_data;
         end else begin
            bank0_d[cnt_q] = in_data;
         end

         if (cnt_end && in_last) begin
            // Complete frame: hand the bank to the read side.
            full_d[wp_q] = 1'b1;
            wp_d         = ~wp_q;
            cnt_d        = 4'd0;
         end else if (cnt_end || in_last) begin
            // Early or missing in_last: drop the frame, bank stays free.
            ferr_d = 1'b1;
            cnt_d  = 4'd0;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end

      // A commit needs !full[wp] and a release needs full[rp], so the two
      // never touch the same bank in one cycle.
      if (release_mat) begin
         full_d[rp_q] = 1'b0;
         rp_d         = ~rp_q;
      end
   end

   // State registers with synchronous reset; reset drops partial and full banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank0_q <= '0;
         bank1_q <= '0;
         full_q  <= 2'b00;
         wp_q    <= 1'b0;
         rp_q    <= 1'b0;
         cnt_q   <= 4'd0;
         ferr_q  <= 1'b0;
      end else begin
         bank0_q <= bank0_d;
         bank1_q <= bank1_d;
         full_q  <= full_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         ferr_q  <= ferr_d;
      end
   end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: the driver keeps a frame-level
// model (list of words per frame) and queues expected matrices and error pulses;
// a separate monitor pops and compares whenever the DUT hands a matrix over.
module tb_matrix_stream_loader;

   localparam int unsigned W  = 32;
   localparam int unsigned MW = 16 * W;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [MW-1:0] mat_data;
   logic          mat_valid;
   logic          mat_ready;
   logic [3:0]    elem_cnt;
   logic          frame_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rdy_mode = 1;  // 0: ready high, 1: ready low, 2: random

   logic [MW-1:0] exp_q[$];
   int            err_q[$];
   logic [W-1:0]  cur[$];

   matrix_stream_loader #(.DATA_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .mat_data  (mat_data),
      .mat_valid (mat_valid),
      .mat_ready (mat_ready),
      .elem_cnt  (elem_cnt),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Frame-level reference: collect words, judge the frame when it ends.
   task automatic model_accept(input logic [W-1:0] d, input logic last);
      logic [MW-1:0] m;
      m = '0;
      cur.push_back(d);
      if (last && cur.size() == 16) begin
         for (int k = 0; k < 16; k++) m[k*W +: W] = cur[k];
         exp_q.push_back(m);
         cur.delete();
      end else if (last || cur.size() == 16) begin
         err_q.push_back(cyc + 1);
         cur.delete();
      end
   endtask

   task automatic send_word(input logic [W-1:0] d, input logic last);
      bit done;
      done     = 1'b0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(d, last);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_word timeout got=in_ready_low exp=accept");
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_rand_frame(input int len, input bit last_at_end, input bit gaps);
      for (int i = 0; i < len; i++) begin
         send_word($urandom, last_at_end && (i == len - 1));
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
   endtask

   // Consumer-side ready driver.
   initial begin
      mat_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       mat_ready = 1'b1;
            1:       mat_ready = 1'b0;
            default: mat_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: error pulses, hold stability and matrix handovers.
   initial begin
      logic          prev_hold;
      logic [MW-1:0] prev_data;
      logic          exp_err;
      prev_hold = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         exp_err = (err_q.size() > 0 && err_q[0] == cyc);
         if (exp_err) void'(err_q.pop_front());
         if (rst) begin
            prev_hold = 1'b0;
         end else begin
            if (frame_err || exp_err) chk("frame_err", MW'(frame_err), MW'(exp_err));
            if (prev_hold) begin
               chk("hold_valid", MW'(mat_valid), MW'(1'b1));
               chk("hold_data", mat_data, prev_data);
            end
            if (mat_valid && mat_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_mat", MW'(mat_valid), MW'(1'b0));
               end else begin
                  chk("mat_data", mat_data, exp_q.pop_front());
               end
            end
            prev_hold = mat_valid && !mat_ready;
            prev_data = mat_data;
         end
      end
   end

   initial begin
      logic [W-1:0]  c0;
      logic [MW-1:0] ident;
      int            wait_cnt;

      rst      = 1'b1;
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", MW'(in_ready), MW'(1'b0));
      chk("rst_mat_valid", MW'(mat_valid), MW'(1'b0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("init_elem_cnt", MW'(elem_cnt), MW'(4'd0));
      chk("init_in_ready", MW'(in_ready), MW'(1'b1));
      chk("init_frame_err", MW'(frame_err), MW'(1'b0));
      @(posedge clk);
      #1;

      // 1: words 1..16, consumer ready.
      rdy_mode = 0;
      idle(2);
      for (int i = 0; i < 16; i++) send_word(W'(i + 1), i == 15);
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      chk("t1_valid_after_commit", MW'(mat_valid), MW'(1'b1));
      chk("t1_elem0", MW'(mat_data[W-1:0]), MW'(32'h1));
      chk("t1_elem15", MW'(mat_data[15*W +: W]), MW'(32'h10));
      chk("t1_elem_cnt", MW'(elem_cnt), MW'(4'd0));
      @(negedge clk);
      chk("t1_valid_one_cycle", MW'(mat_valid), MW'(1'b0));
      @(posedge clk);
      #1;

      // 2: back-pressure, three matrices A, B, C.
      rdy_mode = 1;
      idle(2);
      send_rand_frame(16, 1'b1, 1'b0);
      send_rand_frame(16, 1'b1, 1'b0);
      c0       = $urandom;
      in_data  = c0;
      in_last  = 1'b0;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t2_in_ready_low", MW'(in_ready), MW'(1'b0));
         chk("t2_mat_valid_held", MW'(mat_valid), MW'(1'b1));
      end
      @(posedge clk);
      #1;
      rdy_mode = 0;
      send_word(c0, 1'b0);
      send_rand_frame(15, 1'b1, 1'b0);
      idle(4);

      // 3: in_last on the 5th word, then a good frame.
      send_rand_frame(5, 1'b1, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      chk("t3_err_pulse", MW'(frame_err), MW'(1'b1));
      chk("t3_no_valid", MW'(mat_valid), MW'(1'b0));
      chk("t3_elem_cnt", MW'(elem_cnt), MW'(4'd0));
      @(posedge clk);
      #1;
      send_rand_frame(16, 1'b1, 1'b0);
      idle(3);

      // 4: 16 words without in_last.
      send_rand_frame(16, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_err_pulse", MW'(frame_err), MW'(1'b1));
      chk("t4_no_valid", MW'(mat_valid), MW'(1'b0));
      chk("t4_elem_cnt", MW'(elem_cnt), MW'(4'd0));
      @(posedge clk);
      #1;
      idle(2);

      // 5: reset mid-frame with a full bank pending.
      rdy_mode = 1;
      idle(2);
      send_rand_frame(16, 1'b1, 1'b0);
      send_rand_frame(7, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      chk("t5_rst_mat_valid", MW'(mat_valid), MW'(1'b0));
      exp_q.delete();
      err_q.delete();
      cur.delete();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      rdy_mode = 0;
      @(negedge clk);
      chk("t5_mat_valid", MW'(mat_valid), MW'(1'b0));
      chk("t5_elem_cnt", MW'(elem_cnt), MW'(4'd0));
      chk("t5_in_ready", MW'(in_ready), MW'(1'b1));
      @(posedge clk);
      #1;
      send_rand_frame(16, 1'b1, 1'b0);
      idle(3);

      // 6: identity matrix.
      ident = '0;
      for (int i = 0; i < 16; i++) begin
         c0 = (i % 5 == 0) ? 32'h3F800000 : 32'h0;
         ident[i*W +: W] = c0;
         send_word(c0, i == 15);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      chk("t6_identity", mat_data, ident);
      @(posedge clk);
      #1;
      idle(2);

      // 7: random frames, random gaps and random consumer readiness.
      rdy_mode = 2;
      for (int f = 0; f < 14; f++) begin
         case ($urandom_range(0, 6))
            0:       send_rand_frame($urandom_range(1, 15), 1'b1, 1'b1);
            1:       send_rand_frame(16, 1'b0, 1'b1);
            default: send_rand_frame(16, 1'b1, 1'b1);
         endcase
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      // Drain.
      in_valid = 1'b0;
      in_last  = 1'b0;
      rdy_mode = 0;
      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 200) begin
         @(posedge clk);
         wait_cnt++;
      end
      idle(3);
      chk("drain_matrices", MW'(exp_q.size()), MW'(0));
      chk("drain_errors", MW'(err_q.size()), MW'(0));
      chk("final_mat_valid", MW'(mat_valid), MW'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for the 4x4 determinant stage.
- Accepts matrix elements one word per cycle on a valid/ready stream, in row-major order (element k = row k/4, column k%4).
- Assembles each group of 16 words into a full matrix in a ping-pong pair of register banks.
- Presents the completed matrix in parallel, with a valid/ready handshake, to the combinational determinant/inverse logic, so loading of the next matrix overlaps consumption of the current one.

Parameters:
DATA_W, 32, element width in bits (IEEE-754 single in this design; the block treats it as opaque data)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_data  input  DATA_W  matrix element, row-major order
in_valid  input  1  in_data valid this cycle
in_last  input  1  marks final (16th) element of a matrix
in_ready  output  1  loader can accept in_data this cycle
mat_data  output  16*DATA_W  assembled matrix; element k at bits [k*DATA_W+DATA_W-1 : k*DATA_W]
mat_valid  output  1  mat_data holds a complete matrix
mat_ready  input  1  consumer takes the matrix this cycle
elem_cnt  output  4  index of next element to be written (0..15)
frame_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Storage:
  - Banks B0 and B1, each 16 x DATA_W, with full flags F0 and F1.
  - Write pointer wp and read pointer rp, each 1 bit.
- Reset (rst high at a clock edge):
  - elem_cnt=0, wp=0, rp=0, F0=F1=0, frame_err=0, all bank words 0.
  - Reset mid-frame discards both the partial frame and any full banks.
  - in_ready=0 and mat_valid=0 while rst is high.
- Input side:
  - in_ready = !F[wp] && !rst.
  - Accept = in_valid && in_ready. On accept, B[wp][elem_cnt] <= in_data.
  - Accept with elem_cnt<15 and in_last=0: elem_cnt++.
  - Accept with elem_cnt==15 and in_last=1: F[wp]<=1, wp toggles, elem_cnt<=0 (commit).
  - Accept with elem_cnt<15 and in_last=1: frame_err=1 next cycle, elem_cnt<=0, bank not marked full (partial frame dropped).
  - Accept with elem_cnt==15 and in_last=0: frame_err=1 next cycle, elem_cnt<=0, frame dropped, no commit.
  - in_valid with in_ready=0: no write, no state change. Source holds data.
- Output side:
  - mat_valid = F[rp]. mat_data = B[rp], driven straight from registers with no arithmetic.
  - mat_valid && mat_ready: F[rp]<=0, rp toggles.
  - mat_data and mat_valid stay stable while mat_valid && !mat_ready.
- Latency and throughput:
  - Commit at edge t gives mat_valid=1 from t+1 (when rp==committing bank).
  - Sustained throughput is one word per cycle, one matrix per 16 cycles with mat_ready held high. No bubble between back-to-back matrices.
- Simultaneous events:
  - Commit and release in the same cycle always target different banks, so both take effect.
  - If commit fills the second bank while the first is still held, in_ready drops the next cycle.
  - frame_err is a one-cycle pulse only, and is 0 in every cycle without a violation.

Test Plan:
1. Stream words 32'h1..32'h10 with in_last on the 16th and mat_ready=1. Required: mat_valid high exactly one cycle, the cycle after the last accept; element 0=32'h1, element 15=32'h10; elem_cnt back to 0.
2. mat_ready=0; stream 48 words (matrices A, B, C) continuously. Required: in_ready low after the 32nd accept; C's first word held. Then raise mat_ready. Required: A, B, C are delivered in order; no word lost or duplicated.
3. Assert in_last on the 5th word. Required: frame_err pulse one cycle, no mat_valid. The following 16 words (last on 16th) produce one correct matrix.
4. Send 16 words without in_last on the 16th. Required: frame_err pulse, no mat_valid, elem_cnt=0.
5. Assert rst after 7 accepted words, with one full bank pending. Required: mat_valid=0, elem_cnt=0, in_ready=1 after reset. A fresh frame then loads correctly.
6. Identity matrix: 32'h3F800000 on elements 0, 5, 10, 15 and 0 elsewhere, feeding the determinant stage. Required: mat_data matches bit-exactly and the determinant output is 32'h3F800000.
